// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and default UART parameters.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DIV_WIDTH = 16;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divides clk by max(rate,1) into single-cycle baud ticks.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] rate,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, reload;
  assign reload = (rate == '0) ? '0 : rate - DIV_WIDTH'(1);
  assign tick   = !clear && (cnt_q == '0);
  assign cnt_d  = (clear || tick) ? reload : cnt_q - DIV_WIDTH'(1);
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with a single-entry ready/valid holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DIV_WIDTH  = UART_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 en,
  input  logic [DIV_WIDTH-1:0] rate,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  rx_state_t            state_q;
  logic                 rx_meta_q, rx_s_q;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q;
  logic                 deliver_q, valid_q, fe_q, ov_q;
  logic                 tick, baud_clear;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  // Holding the divider in reload while idle phase-aligns ticks to each start edge.
  assign baud_clear = !en || (state_q == IDLE);
  uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk   (clk),
    .nReset(nReset),
    .clear (baud_clear),
    .rate  (rate),
    .tick  (tick)
  );
  assign scnt_d  = scnt_q + SW'(1);
  assign shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      state_q   <= IDLE;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      deliver_q <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      deliver_q <= 1'b0;
      fe_q      <= 1'b0;
      if (!en) begin
        state_q <= IDLE;
        scnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            scnt_q <= '0;
            if (!rx_s_q) state_q <= START;
          end
          START:
            if (tick) begin
              if (scnt_q == S_HALF) begin
                scnt_q  <= '0;
                bcnt_q  <= '0;
                state_q <= rx_s_q ? IDLE : DATA;
              end else scnt_q <= scnt_d;
            end
          DATA:
            if (tick) begin
              if (scnt_q == S_LAST) begin
                scnt_q  <= '0;
                shift_q <= shift_d;
                if (bcnt_q == B_LAST) state_q <= STOP;
                else                  bcnt_q  <= bcnt_q + BW'(1);
              end else scnt_q <= scnt_d;
            end
          STOP:
            if (tick) begin
              if (scnt_q == S_LAST) begin
                scnt_q    <= '0;
                deliver_q <= rx_s_q;
                fe_q      <= !rx_s_q;
                state_q   <= rx_s_q ? IDLE : BREAK_WAIT;
              end else scnt_q <= scnt_d;
            end
          BREAK_WAIT:
            if (rx_s_q) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  // A transfer in the delivery cycle frees the slot, so the new byte is kept.
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      if (deliver_q) begin
        if (!valid_q || data_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else ov_q <= 1'b1;
      end else if (valid_q && data_ready) valid_q <= 1'b0;
    end
  assign data_out      = data_q;
  assign data_valid    = valid_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frame-level checks of uart_rx against a byte-queue model.
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        nReset, en, rx, data_ready;
  logic [15:0] rate;
  logic [7:0]  data_out;
  logic        data_valid, framing_error, overrun, busy;
  int checks = 0, errors = 0;
  int fe_cnt = 0, ov_cnt = 0, vcyc = 0;
  int rd = 0, v0, f0, o0, k, k0, k1;
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic [7:0] b;
  int r;
  always #5 clk = ~clk;
  uart_rx dut (
    .clk          (clk),
    .nReset       (nReset),
    .en           (en),
    .rate         (rate),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun      (overrun),
    .busy         (busy)
  );
  always @(negedge clk)
    if (nReset) begin
      if (data_valid && data_ready) rxq.push_back(data_out);
      if (framing_error) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (data_valid) vcyc <= vcyc + 1;
    end
  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] byt, input logic stopv, input int rr);
    int p;
    p = 16 * ((rr == 0) ? 1 : rr);
    rate = 16'(rr);
    rx = 1'b0;
    cyc(p);
    for (int i = 0; i < 8; i++) begin
      rx = byt[i];
      cyc(p);
    end
    rx = stopv;
    cyc(p);
  endtask
  task automatic measure(output int kk);
    kk = 0;
    while (data_valid !== 1'b1 && kk < 5000) begin
      cyc(1);
      kk++;
    end
  endtask
  task automatic expect_rx(input string tag);
    chk({tag, "_count"}, rxq.size() - rd, expq.size());
    for (int i = 0; i < expq.size(); i++)
      if (rd + i < rxq.size()) chk(tag, 32'(rxq[rd+i]), 32'(expq[i]));
      else chk(tag, 32'hFFFF_FFFF, 32'(expq[i]));
    rd = rxq.size();
    expq.delete();
  endtask
  initial begin
    nReset = 1'b0; en = 1'b1; rate = 16'd4; rx = 1'b1; data_ready = 1'b1;
    cyc(3);
    chk("rst_valid", data_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_fe", framing_error, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_busy", busy, 0);
    nReset = 1'b1;
    cyc(5);
    v0 = vcyc; f0 = fe_cnt; o0 = ov_cnt;
    send(8'hA5, 1'b1, 4);
    cyc(20);
    expq.push_back(8'hA5);
    expect_rx("a5");
    chk("a5_valid_cycles", vcyc - v0, 1);
    chk("a5_fe", fe_cnt - f0, 0);
    chk("a5_ov", ov_cnt - o0, 0);
    chk("a5_busy", busy, 0);
    rx = 1'b0;
    cyc(10);
    chk("glitch_busy_hi", busy, 1);
    cyc(10);
    rx = 1'b1;
    cyc(60);
    chk("glitch_busy_lo", busy, 0);
    chk("glitch_valid", data_valid, 0);
    expect_rx("glitch");
    f0 = fe_cnt;
    send(8'h3C, 1'b0, 4);
    cyc(200);
    chk("break_fe", fe_cnt - f0, 1);
    chk("break_busy", busy, 1);
    chk("break_valid", data_valid, 0);
    rx = 1'b1;
    cyc(5);
    chk("break_exit", busy, 0);
    send(8'h5A, 1'b1, 4);
    cyc(20);
    expq.push_back(8'h5A);
    expect_rx("after_break");
    data_ready = 1'b0;
    o0 = ov_cnt;
    send(8'h11, 1'b1, 4);
    send(8'h22, 1'b1, 4);
    cyc(20);
    chk("ovr_valid", data_valid, 1);
    chk("ovr_data", data_out, 8'h11);
    chk("ovr_pulse", ov_cnt - o0, 1);
    data_ready = 1'b1;
    cyc(1);
    data_ready = 1'b0;
    cyc(2);
    expq.push_back(8'h11);
    expect_rx("ovr_drain");
    chk("ovr_valid_fall", data_valid, 0);
    fork
      send(8'h33, 1'b1, 4);
      measure(k);
    join
    chk("lat_r4", (k >= 608 && k <= 616), 1);
    cyc(20);
    chk("pend_valid", data_valid, 1);
    chk("pend_data", data_out, 8'h33);
    o0 = ov_cnt;
    fork
      send(8'h44, 1'b1, 4);
      begin
        cyc(k - 1);
        data_ready = 1'b1;
        cyc(1);
        data_ready = 1'b0;
      end
    join
    cyc(20);
    chk("coinc_valid", data_valid, 1);
    chk("coinc_data", data_out, 8'h44);
    chk("coinc_ov", ov_cnt - o0, 0);
    expq.push_back(8'h33);
    expect_rx("coinc_xfer");
    data_ready = 1'b1;
    cyc(2);
    expq.push_back(8'h44);
    expect_rx("coinc_drain");
    chk("coinc_valid_fall", data_valid, 0);
    fork
      send(8'h77, 1'b1, 4);
      begin
        cyc(100);
        en = 1'b0;
        cyc(2);
        chk("en_abort_busy", busy, 0);
      end
    join
    en = 1'b1;
    cyc(20);
    expect_rx("en_abort");
    fork
      send(8'hFF, 1'b1, 4);
      begin
        cyc(64 * 3);
        nReset = 1'b0;
        cyc(1);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", data_valid, 0);
        nReset = 1'b1;
      end
    join
    cyc(10);
    send(8'h81, 1'b1, 4);
    cyc(20);
    expq.push_back(8'h81);
    expect_rx("after_rst");
    fork
      send(8'hC3, 1'b1, 1);
      measure(k1);
    join
    cyc(20);
    fork
      send(8'h96, 1'b1, 0);
      measure(k0);
    join
    cyc(20);
    chk("rate0_eq_rate1", k0, k1);
    chk("lat_r1", (k1 >= 152 && k1 <= 160), 1);
    expq.push_back(8'hC3);
    expq.push_back(8'h96);
    expect_rx("rate01");
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      r = $urandom_range(0, 3);
      send(b, 1'b1, r);
      expq.push_back(b);
      cyc($urandom_range(0, 20));
    end
    cyc(20);
    expect_rx("rand");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
